// File: rtl/regfile_seq_ctrl.sv
// Moore controller that steps one 16-bit instruction through the register file
// and ALU datapath: read-A, read-B, ALU, writeback.
module regfile_seq_ctrl (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        s_i,
   input  logic [15:0] instr_i,
   output logic        w_o,
   output logic [2:0]  readnum_o,
   output logic [2:0]  writenum_o,
   output logic        write_o,
   output logic        loada_o,
   output logic        loadb_o,
   output logic        loadc_o,
   output logic        loads_o,
   output logic        asel_o,
   output logic [1:0]  aluop_o,
   output logic [1:0]  vsel_o,
   output logic        illegal_o
);

   localparam int unsigned IR_W  = 16;
   localparam int unsigned IDX_W = 3;

   typedef enum logic [2:0] {
      S_WAIT, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B, S_ALU, S_WR_C, S_BAD
   } state_e;

   typedef struct packed {
      logic             w;
      logic [IDX_W-1:0] readnum;
      logic [IDX_W-1:0] writenum;
      logic             write;
      logic             loada;
      logic             loadb;
      logic             loadc;
      logic             loads;
      logic             asel;
      logic [1:0]       aluop;
      logic [1:0]       vsel;
      logic             illegal;
   } ctrl_t;

   localparam ctrl_t CTRL_WAIT = '{w: 1'b1, default: '0};

   state_e          state_q, state_d;
   logic [IR_W-1:0] ir_q, ir_d;
   ctrl_t           ctrl_q, ctrl_d;

   logic [2:0]       opcode;
   logic [1:0]       op;
   logic [IDX_W-1:0] rn, rd, rm;
   logic             is_cmp;

   assign opcode = ir_q[15:13];
   assign op     = ir_q[12:11];
   assign rn     = ir_q[10:8];
   assign rd     = ir_q[7:5];
   assign rm     = ir_q[2:0];
   assign is_cmp = ({opcode, op} == 5'b101_01);

   // Next state and instruction latch
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      case (state_q)
         S_WAIT: begin
            if (s_i) begin
               state_d = S_DECODE;
               ir_d    = instr_i;
            end
         end
         S_DECODE: begin
            case ({opcode, op})
               5'b110_10:                     state_d = S_WR_IMM;
               5'b110_00, 5'b101_11:          state_d = S_GET_B;
               5'b101_00, 5'b101_01, 5'b101_10: state_d = S_GET_A;
               default:                       state_d = S_BAD;
            endcase
         end
         S_WR_IMM: state_d = S_WAIT;
         S_GET_A:  state_d = S_GET_B;
         S_GET_B:  state_d = S_ALU;
         S_ALU:    state_d = is_cmp ? S_WAIT : S_WR_C;
         S_WR_C:   state_d = S_WAIT;
         S_BAD:    state_d = S_WAIT;
         default:  state_d = S_WAIT;
      endcase
   end

   // Strobes for the state being entered, so every output comes straight from a flop
   always_comb begin
      ctrl_d = '0;
      case (state_d)
         S_WAIT: ctrl_d.w = 1'b1;
         S_WR_IMM: begin
            ctrl_d.writenum = rn;
            ctrl_d.vsel     = 2'b01;
            ctrl_d.write    = 1'b1;
         end
         S_GET_A: begin
            ctrl_d.readnum = rn;
            ctrl_d.loada   = 1'b1;
         end
         S_GET_B: begin
            ctrl_d.readnum = rm;
            ctrl_d.loadb   = 1'b1;
         end
         S_ALU: begin
            ctrl_d.aluop = (opcode == 3'b110) ? 2'b00 : op;
            ctrl_d.asel  = (opcode == 3'b110);
            ctrl_d.loads = is_cmp;
            ctrl_d.loadc = !is_cmp;
         end
         S_WR_C: begin
            ctrl_d.writenum = rd;
            ctrl_d.vsel     = 2'b00;
            ctrl_d.write    = 1'b1;
         end
         S_BAD:   ctrl_d.illegal = 1'b1;
         default: ctrl_d = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_WAIT;
         ir_q    <= '0;
         ctrl_q  <= CTRL_WAIT;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign w_o        = ctrl_q.w;
   assign readnum_o  = ctrl_q.readnum;
   assign writenum_o = ctrl_q.writenum;
   assign write_o    = ctrl_q.write;
   assign loada_o    = ctrl_q.loada;
   assign loadb_o    = ctrl_q.loadb;
   assign loadc_o    = ctrl_q.loadc;
   assign loads_o    = ctrl_q.loads;
   assign asel_o     = ctrl_q.asel;
   assign aluop_o    = ctrl_q.aluop;
   assign vsel_o     = ctrl_q.vsel;
   assign illegal_o  = ctrl_q.illegal;

endmodule
